// File: rtl/seg_pkg.sv
// Shared 9-segment definitions: code table, blank pattern and per-digit decode result.
package seg_pkg;

    localparam int unsigned SEG_W = 9;

    localparam logic [SEG_W-1:0] SEG_BLANK = 9'b000000001;

    // Also consumed by the display driver so encoder and decoder stay in lockstep.
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        9'b111111000, 9'b011000000, 9'b110110100, 9'b111100100,
        9'b011001100, 9'b101101100, 9'b101111100, 9'b111000000,
        9'b111111100, 9'b111101100, 9'b111011100, 9'b001111100,
        9'b100111000, 9'b011110100, 9'b100111100, 9'b100011100
    };

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       err;
    } seg_dec_t;

    typedef enum logic {
        ST_TRACK,
        ST_LOCKED
    } trk_state_t;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational decode of one 9-segment pattern back to a nibble with blank/illegal flags.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output seg_dec_t         dec
);

    always_comb begin
        dec = '{nibble: '0, blank: 1'b0, err: 1'b1};
        if (pattern == SEG_BLANK) begin
            dec.blank = 1'b1;
            dec.err   = 1'b0;
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX[i]) begin
                dec.nibble = i[3:0];
                dec.err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_reader.sv
// Recovers the 8-bit value shown on two 9-segment buses after a stability filter,
// presenting each new stable reading on a valid/ready interface with overrun flag.
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] seg1,
    input  logic [SEG_W-1:0] seg2,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic             out_valid,
    output logic [7:0]       value,
    output logic [1:0]       out_blank,
    output logic             out_err,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [2*SEG_W-1:0] samp;
    logic [2*SEG_W-1:0] last_rep;
    logic               last_ok;
    logic [CNT_W-1:0]   cnt;
    trk_state_t         state;
    trk_state_t         state_nxt;
    logic               evt;
    logic               load;
    logic               drop;
    seg_dec_t           dec1;
    seg_dec_t           dec2;

    seg_digit_decode u_dec1 (.pattern(samp[2*SEG_W-1:SEG_W]), .dec(dec1));
    seg_digit_decode u_dec2 (.pattern(samp[SEG_W-1:0]),       .dec(dec2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            cnt  <= '0;
        end else begin
            samp <= {seg1, seg2};
            if ({seg1, seg2} == samp) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
            end else begin
                cnt <= CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_TRACK;
        else
            state <= state_nxt;
    end

    // State lags the counter by one edge, so TRACK with a saturated count marks the
    // single cycle in which the counter has just reached STABLE_CYCLES.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_TRACK:  if (cnt == CNT_MAX) state_nxt = ST_LOCKED;
            ST_LOCKED: if (cnt != CNT_MAX) state_nxt = ST_TRACK;
            default:   state_nxt = ST_TRACK;
        endcase
    end

    always_comb begin
        evt  = (state == ST_TRACK) && (cnt == CNT_MAX) && (!last_ok || (samp != last_rep));
        load = evt && (!out_valid || out_ready);
        drop = evt && out_valid && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            value     <= '0;
            out_blank <= '0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
            last_rep  <= '0;
            last_ok   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                value     <= {dec1.nibble, dec2.nibble};
                out_blank <= {dec1.blank, dec2.blank};
                out_err   <= dec1.err | dec2.err;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            // A dropped reading still counts as reported.
            if (evt) begin
                last_rep <= samp;
                last_ok  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: directed segment patterns with hand-computed readings.
module tb_seg_reader;

    localparam logic [8:0] P1   = 9'b011000000;
    localparam logic [8:0] P2   = 9'b110110100;
    localparam logic [8:0] P3   = 9'b111100100;
    localparam logic [8:0] P4   = 9'b011001100;
    localparam logic [8:0] P5   = 9'b101101100;
    localparam logic [8:0] P6   = 9'b101111100;
    localparam logic [8:0] P7   = 9'b111000000;
    localparam logic [8:0] P9   = 9'b111101100;
    localparam logic [8:0] PD   = 9'b011110100;
    localparam logic [8:0] PBL  = 9'b000000001;
    localparam logic [8:0] PBAD = 9'b000000011;

    typedef struct packed {
        logic [7:0] v;
        logic [1:0] b;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] seg1;
    logic [8:0] seg2;
    logic       out_ready;
    logic       clr_overrun;
    logic       out_valid;
    logic [7:0] value;
    logic [1:0] out_blank;
    logic       out_err;
    logic       overrun;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    seg_reader #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg1       (seg1),
        .seg2       (seg2),
        .out_ready  (out_ready),
        .clr_overrun(clr_overrun),
        .out_valid  (out_valid),
        .value      (value),
        .out_blank  (out_blank),
        .out_err    (out_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_seg(input logic [8:0] a, input logic [8:0] b);
        seg1 = a;
        seg2 = b;
    endtask

    task automatic expect_rd(input logic [7:0] v, input logic [1:0] b, input logic e);
        exp_q.push_back('{v: v, b: b, e: e});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: every accepted transfer is compared against the oldest expected reading.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got v=%h b=%b e=%b expected none", value, out_blank, out_err);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if ({value, out_blank, out_err} !== {x.v, x.b, x.e}) begin
                    n_fail++;
                    $display("FAIL read: got v=%h b=%b e=%b expected v=%h b=%b e=%b",
                             value, out_blank, out_err, x.v, x.b, x.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
        set_seg(P9, PD);
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_value", value, 0);
        check("rst_blank", out_blank, 0);
        check("rst_err", out_err, 0);
        check("rst_overrun", overrun, 0);

        // 9D held from the first edge after release
        expect_rd(8'h9D, 2'b00, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(4);
        check("lat_early", out_valid, 0);
        step(1);
        check("lat_valid", out_valid, 1);
        check("lat_value", value, 8'h9D);
        step(3);
        check("hold_valid", out_valid, 1);
        check("hold_value", value, 8'h9D);
        out_ready = 1'b1;
        step(1);
        check("accept_drop", out_valid, 0);

        // glitch on seg2 then revert to the reported pattern
        set_seg(P9, P1);
        step(2);
        set_seg(P9, PD);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("glitch_noevt", out_valid, 0);
        end

        // blank and illegal digits
        set_seg(PBL, P7);
        expect_rd(8'h07, 2'b10, 1'b0);
        drain("drain_blank");
        set_seg(PBL, PBAD);
        expect_rd(8'h00, 2'b10, 1'b1);
        drain("drain_err");

        // overrun: 12 pending, 34 dropped
        out_ready = 1'b0;
        set_seg(P1, P2);
        expect_rd(8'h12, 2'b00, 1'b0);
        step(6);
        check("ovr_pend", out_valid, 1);
        set_seg(P3, P4);
        step(6);
        check("ovr_set", overrun, 1);
        check("ovr_value", value, 8'h12);
        out_ready = 1'b1;
        step(1);
        check("ovr_accept", out_valid, 0);
        check("ovr_sticky", overrun, 1);
        out_ready   = 1'b0;
        clr_overrun = 1'b1;
        step(1);
        clr_overrun = 1'b0;
        check("ovr_clr", overrun, 0);

        // accept and new event on the same edge
        set_seg(P1, P2);
        expect_rd(8'h12, 2'b00, 1'b0);
        step(6);
        check("same_pend", out_valid, 1);
        set_seg(P5, P6);
        step(4);
        out_ready = 1'b1;
        expect_rd(8'h56, 2'b00, 1'b0);
        step(1);
        check("same_valid", out_valid, 1);
        check("same_value", value, 8'h56);
        check("same_ovr", overrun, 0);
        step(1);
        check("same_done", out_valid, 0);

        // reset mid-settle
        out_ready = 1'b0;
        set_seg(P9, PD);
        step(2);
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        check("rst1_valid", out_valid, 0);
        check("rst1_value", value, 0);
        step(1);
        rst_n = 1'b1;
        expect_rd(8'h9D, 2'b00, 1'b0);
        step(6);
        check("rst1_rep", out_valid, 1);
        check("rst1_rval", value, 8'h9D);

        // reset while a reading is pending and overrun is set
        set_seg(P1, P2);
        step(6);
        check("rst2_ovr_pre", overrun, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        check("rst2_valid", out_valid, 0);
        check("rst2_value", value, 0);
        check("rst2_ovr", overrun, 0);
        step(1);
        rst_n = 1'b1;
        expect_rd(8'h12, 2'b00, 1'b0);
        step(4);
        check("rst2_early", out_valid, 0);
        step(1);
        check("rst2_rep", out_valid, 1);
        out_ready = 1'b1;
        drain("drain_rst2");

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_reader.md
Name: seg_reader

Overview:
- Receive-side counterpart of the two-digit 9-segment hex display driver: watches the two 9-bit segment buses and recovers the 8-bit value they show.
- Applies a stability filter, decodes each digit back to a nibble, flags blank and illegal patterns, and presents each new stable reading on a valid/ready interface.
- Used as a loopback checker and self-test monitor alongside the display path.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples of {seg1,seg2} required before a reading is accepted. Legal range 2..255.
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width. Derived; do not override.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg1  input  9  segment pattern, high digit.
- seg2  input  9  segment pattern, low digit.
- out_ready  input  1  consumer accepts the current reading.
- clr_overrun  input  1  single-cycle pulse that clears overrun.
- out_valid  output  1  reading available; held until accepted.
- value  output  8  decoded value {digit1,digit2}.
- out_blank  output  2  [1]=seg1 blank, [0]=seg2 blank.
- out_err  output  1  at least one digit is neither a hex code nor blank.
- overrun  output  1  sticky: a reading was dropped.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, value=8'h00, out_blank=2'b00, out_err=0, overrun=0. Sample register=0, counter=0, last-reported register marked invalid.
- Sampling:
  - {seg1,seg2} is registered every edge.
  - If the new sample equals the previous sample, the counter increments, saturating at STABLE_CYCLES. Otherwise the counter loads 1.
- Latency: a pattern first present before edge N and held constant reaches count STABLE_CYCLES at edge N+STABLE_CYCLES-1. The event is registered so that out_valid=1 after edge N+STABLE_CYCLES.
- Event rules:
  - An event fires once per stable episode: on the cycle the counter transitions to STABLE_CYCLES.
  - An event fires only if the pattern differs from the last reported pattern. The first stable pattern after reset always reports.
  - A glitch shorter than STABLE_CYCLES produces no event. A glitch that reverts to the last reported pattern produces no event.
- Decode, per digit (table in package):
  - Hex codes: 0=111111000, 1=011000000, 2=110110100, 3=111100100, 4=011001100, 5=101101100, 6=101111100, 7=111000000, 8=111111100, 9=111101100, A=111011100, B=001111100, C=100111000, D=011110100, E=100111100, F=100011100.
  - Blank = 000000001: nibble 0, blank bit set.
  - Any other pattern: nibble 0, out_err=1.
- Handshake:
  - out_valid/value/out_blank/out_err hold constant while out_valid=1 and out_ready=0.
  - A transfer completes on an edge with out_valid&out_ready. out_valid then drops unless a new event lands on that same edge, in which case the new reading loads and out_valid stays 1 with no overrun.
  - An event while out_valid=1 and out_ready=0 is dropped: outputs unchanged, overrun<=1. The last-reported register still updates to the dropped pattern.
  - overrun clears on clr_overrun=1. If a set and clr_overrun coincide, set wins.
- State machine, for stability tracking: TRACK (counter<STABLE_CYCLES), LOCKED (saturated). LOCKED->TRACK on any sample change. The event is the TRACK->LOCKED transition gated by the differs-from-last check.
- Reset mid-operation: all state clears immediately. A pending reading is lost. The first stable pattern after release reports even if equal to the pre-reset value.

Decomposition:
- Package seg_pkg:
  - SEG_W=9.
  - SEG_BLANK constant.
  - 16-entry SEG_HEX code table, shared with the display driver so the encoder and decoder cannot drift.
  - Typedef seg_dec_t {nibble[3:0], blank, err}.
- One sub-module seg_digit_decode: combinational 9-bit pattern -> seg_dec_t. Instantiated twice.
- Filter, event logic and handshake stay in seg_reader.

Test Plan:
- Reset then seg1=111101100 (9), seg2=011110100 (d) held, out_ready=0, STABLE_CYCLES=4 -> out_valid=1 after edge 4, value=8'h9D, out_blank=00, out_err=0; holds until out_ready=1, then out_valid=0 next edge.
- Stable 8'h9D accepted; seg2 glitches to 011000000 for 2 cycles, then reverts -> no event, out_valid stays 0.
- seg1=000000001, seg2=111000000 held -> value=8'h07, out_blank=2'b10, out_err=0. Then seg2=000000011 held -> value=8'h00, out_err=1.
- out_ready=0; stable 8'h12 reported, then stable 8'h34 -> value stays 8'h12, overrun=1. Accept -> out_valid=0. clr_overrun pulse -> overrun=0.
- Pending 8'h12, out_ready=1 on the same edge the 8'h56 event fires -> value=8'h56, out_valid=1, overrun=0.
- rst_n asserted mid-settle and while out_valid=1 -> all outputs 0 asynchronously. After release, previous pattern held -> re-reported after STABLE_CYCLES edges.
